// File: rtl/npc_pkg.sv
// Shared definitions for the integer write-back path: default widths,
// the hard-wired zero register index and a write-request record.
package npc_pkg;

    localparam int NPC_ADDR_WIDTH = 5;
    localparam int NPC_DATA_WIDTH = 32;

    // x0 is hard-wired to zero: never written, never busy.
    localparam int X0_IDX = 0;

    // One register-file write request at the default widths.
    typedef struct packed {
        logic [NPC_ADDR_WIDTH-1:0] rd;
        logic [NPC_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wbu_scoreboard.sv
// Per-register busy scoreboard. A register becomes busy when an instruction
// targeting it issues and stays busy until its register-file write has
// been performed. Queries are combinational with no write bypass.
module wbu_scoreboard
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH = NPC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_idx,
    input  logic [ADDR_WIDTH-1:0] chk_rs1,
    input  logic [ADDR_WIDTH-1:0] chk_rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Per-register next state: x0 is constant zero, otherwise a set in the
    // same cycle as a clear of the same index keeps the register busy.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
        if (gi == X0_IDX) begin : g_x0
            assign busy_d[gi] = 1'b0;
        end else begin : g_reg
            logic set_hit;
            logic clr_hit;
            assign set_hit    = set_en && (set_idx == ADDR_WIDTH'(gi));
            assign clr_hit    = clr_en && (clr_idx == ADDR_WIDTH'(gi));
            assign busy_d[gi] = set_hit || (busy_q[gi] && !clr_hit);
        end
    end

    // Busy vector register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy = busy_q[chk_rs1];
    assign rs2_busy = busy_q[chk_rs2];

endmodule

// File: rtl/wbu.sv
// Write-back unit: arbitrates load returns, a one-entry pending buffer and
// ALU results onto the single register-file write port, and tracks
// outstanding writes in a busy scoreboard for decode hazard checks.
module wbu
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH = NPC_ADDR_WIDTH,
    parameter int DATA_WIDTH = NPC_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wen,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_rd,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic [ADDR_WIDTH-1:0] chk_rs1,
    input  logic [ADDR_WIDTH-1:0] chk_rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(X0_IDX);

    // Local request record sized to this instance's parameters.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t                  pend_q;
    logic                  pend_v_q;
    logic                  rf_wen_q;
    logic [ADDR_WIDTH-1:0] rf_waddr_q;
    logic [DATA_WIDTH-1:0] rf_wdata_q;

    logic alu_req;
    logic ld_req;

    // The pending buffer is the only source of backpressure.
    assign in_ready = !pend_v_q && !rst;

    // Beats that do not write (in_wen low or rd = x0) are simply consumed.
    assign alu_req = in_valid && in_ready && in_wen && (in_rd != X0);
    assign ld_req  = ld_valid && (ld_rd != X0);

    // Write-slot arbitration (load > pending > ALU) and pending buffer.
    // A load cannot be stalled, so a colliding ALU result is parked.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q   <= 1'b0;
            pend_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_wen_q <= ld_req || pend_v_q || alu_req;
            if (ld_req) begin
                rf_waddr_q <= ld_rd;
                rf_wdata_q <= ld_data;
                if (alu_req) begin
                    pend_q.rd   <= in_rd;
                    pend_q.data <= in_data;
                    pend_v_q    <= 1'b1;
                end
            end else if (pend_v_q) begin
                rf_waddr_q <= pend_q.rd;
                rf_wdata_q <= pend_q.data;
                pend_v_q   <= 1'b0;
            end else if (alu_req) begin
                rf_waddr_q <= in_rd;
                rf_wdata_q <= in_data;
            end
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // Busy tracking: set on issue, cleared once the write has gone out.
    wbu_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (iss_valid && (iss_rd != X0)),
        .set_idx (iss_rd),
        .clr_en  (rf_wen_q),
        .clr_idx (rf_waddr_q),
        .chk_rs1 (chk_rs1),
        .chk_rs2 (chk_rs2),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy)
    );

endmodule

// File: tb/tb_wbu.sv
// Directed testbench for the write-back unit. Inputs are driven 1 ns after
// each rising edge and outputs are checked before the next edge.
module tb_wbu;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          in_valid;
    logic          in_ready;
    logic          in_wen;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_data;
    logic          ld_valid;
    logic [AW-1:0] ld_rd;
    logic [DW-1:0] ld_data;
    logic [AW-1:0] chk_rs1;
    logic [AW-1:0] chk_rs2;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wbu #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_wen   (in_wen),
        .in_rd    (in_rd),
        .in_data  (in_data),
        .ld_valid (ld_valid),
        .ld_rd    (ld_rd),
        .ld_data  (ld_data),
        .chk_rs1  (chk_rs1),
        .chk_rs2  (chk_rs2),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_rd  = '0;
        in_valid  = 1'b0; in_wen  = 1'b0; in_rd = '0; in_data = '0;
        ld_valid  = 1'b0; ld_rd   = '0; ld_data = '0;
    endtask

    task automatic alu(input logic wen, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        in_valid = 1'b1; in_wen = wen; in_rd = rd; in_data = d;
    endtask

    task automatic ld(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        ld_valid = 1'b1; ld_rd = rd; ld_data = d;
    endtask

    task automatic expect_wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        check({tag, ".wen"}, 64'(rf_wen), 64'd1);
        check({tag, ".waddr"}, 64'(rf_waddr), 64'(a));
        check({tag, ".wdata"}, 64'(rf_wdata), 64'(d));
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        chk_rs1 = '0;
        chk_rs2 = '0;

        // ---------------- reset then idle ----------------
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd0);
        tick();
        check("rst.in_ready2", 64'(in_ready), 64'd0);
        tick();
        check("rst.wen", 64'(rf_wen), 64'd0);
        check("rst.waddr", 64'(rf_waddr), 64'd0);
        check("rst.wdata", 64'(rf_wdata), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst.in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 32; i++) begin
            chk_rs1 = AW'(i);
            chk_rs2 = AW'(31 - i);
            #1;
            check($sformatf("rst.rs1_busy[%0d]", i), 64'(rs1_busy), 64'd0);
            check($sformatf("rst.rs2_busy[%0d]", 31 - i), 64'(rs2_busy), 64'd0);
        end

        // ---------------- single ALU write to x5 ----------------
        chk_rs1 = 5'd5;
        iss_valid = 1'b1; iss_rd = 5'd5;              // cycle 0
        #1;
        check("alu.busy_c0", 64'(rs1_busy), 64'd0);
        tick(); idle_inputs();                        // cycle 1
        check("alu.busy_c1", 64'(rs1_busy), 64'd1);
        tick();                                       // cycle 2
        alu(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        check("alu.in_ready_c2", 64'(in_ready), 64'd1);
        check("alu.busy_c2", 64'(rs1_busy), 64'd1);
        tick(); idle_inputs();                        // cycle 3
        expect_wr("alu.c3", 5'd5, 32'hDEADBEEF);
        check("alu.busy_c3", 64'(rs1_busy), 64'd1);
        tick();                                       // cycle 4
        check("alu.wen_c4", 64'(rf_wen), 64'd0);
        check("alu.wdata_hold_c4", 64'(rf_wdata), 64'hDEADBEEF);
        check("alu.busy_c4", 64'(rs1_busy), 64'd0);

        // ---------------- load/ALU collision ----------------
        tick();                                       // cycle N
        ld(5'd3, 32'h11);
        alu(1'b1, 5'd4, 32'h22);
        #1;
        check("col.in_ready_N", 64'(in_ready), 64'd1);
        tick(); idle_inputs();                        // N+1
        check("col.in_ready_N1", 64'(in_ready), 64'd0);
        expect_wr("col.N1", 5'd3, 32'h11);
        tick();                                       // N+2
        expect_wr("col.N2", 5'd4, 32'h22);
        check("col.in_ready_N2", 64'(in_ready), 64'd1);
        tick();                                       // N+3
        check("col.wen_N3", 64'(rf_wen), 64'd0);

        // ---------------- pending starved by back-to-back loads ----------------
        ld(5'd10, 32'hA0);                            // M: collision parks x11
        alu(1'b1, 5'd11, 32'hB0);
        tick();                                       // M+1
        ld(5'd12, 32'hA1);
        alu(1'b1, 5'd15, 32'hCC);                     // held, must not be taken
        #1;
        check("stv.in_ready_M1", 64'(in_ready), 64'd0);
        expect_wr("stv.M1", 5'd10, 32'hA0);
        tick();                                       // M+2
        ld(5'd13, 32'hA2);
        #1;
        check("stv.in_ready_M2", 64'(in_ready), 64'd0);
        expect_wr("stv.M2", 5'd12, 32'hA1);
        tick();                                       // M+3
        ld(5'd14, 32'hA3);
        #1;
        check("stv.in_ready_M3", 64'(in_ready), 64'd0);
        expect_wr("stv.M3", 5'd13, 32'hA2);
        tick();                                       // M+4
        ld_valid = 1'b0;
        #1;
        check("stv.in_ready_M4", 64'(in_ready), 64'd0);
        expect_wr("stv.M4", 5'd14, 32'hA3);
        tick();                                       // M+5: held ALU accepted
        #1;
        check("stv.in_ready_M5", 64'(in_ready), 64'd1);
        expect_wr("stv.M5", 5'd11, 32'hB0);
        tick(); idle_inputs();                        // M+6
        expect_wr("stv.M6", 5'd15, 32'hCC);
        tick();
        check("stv.wen_M7", 64'(rf_wen), 64'd0);

        // ---------------- x0 and no-write beats ----------------
        alu(1'b0, 5'd7, 32'h77);
        #1;
        check("x0.in_ready_nowen", 64'(in_ready), 64'd1);
        tick();
        alu(1'b1, 5'd0, 32'h88);
        #1;
        check("x0.wen_after_nowen", 64'(rf_wen), 64'd0);
        check("x0.in_ready_rd0", 64'(in_ready), 64'd1);
        tick(); idle_inputs();
        ld(5'd0, 32'h99);
        iss_valid = 1'b1; iss_rd = 5'd0;
        #1;
        check("x0.wen_after_rd0", 64'(rf_wen), 64'd0);
        check("x0.in_ready_ld0", 64'(in_ready), 64'd1);
        tick(); idle_inputs();
        chk_rs1 = 5'd0; chk_rs2 = 5'd7;
        #1;
        check("x0.wen_after_ld0", 64'(rf_wen), 64'd0);
        check("x0.wdata_hold", 64'(rf_wdata), 64'hCC);
        check("x0.rs1_busy0", 64'(rs1_busy), 64'd0);
        check("x0.rs2_busy7", 64'(rs2_busy), 64'd0);

        // ---------------- set/clear race on x9 ----------------
        chk_rs1 = 5'd9; chk_rs2 = 5'd9;
        iss_valid = 1'b1; iss_rd = 5'd9;              // A
        tick(); idle_inputs();                        // A+1
        alu(1'b1, 5'd9, 32'h909);
        #1;
        check("race.busy_A1", 64'(rs1_busy), 64'd1);
        tick(); idle_inputs();                        // A+2: write x9, reissue x9
        iss_valid = 1'b1; iss_rd = 5'd9;
        #1;
        expect_wr("race.A2", 5'd9, 32'h909);
        check("race.busy_A2", 64'(rs1_busy), 64'd1);
        tick(); idle_inputs();                        // A+3
        check("race.rs1_busy_A3", 64'(rs1_busy), 64'd1);
        check("race.rs2_busy_A3", 64'(rs2_busy), 64'd1);
        check("race.wen_A3", 64'(rf_wen), 64'd0);

        // ---------------- reset with a pending entry ----------------
        tick();
        ld(5'd20, 32'h2020);                          // R: park x21
        alu(1'b1, 5'd21, 32'h2121);
        tick(); idle_inputs();                        // R+1
        check("rrst.in_ready_R1", 64'(in_ready), 64'd0);
        expect_wr("rrst.R1", 5'd20, 32'h2020);
        rst = 1'b1;
        #1;
        check("rrst.in_ready_in_rst", 64'(in_ready), 64'd0);
        tick();                                       // reset edge taken
        rst = 1'b0;
        #1;
        check("rrst.wen_after", 64'(rf_wen), 64'd0);
        check("rrst.waddr_after", 64'(rf_waddr), 64'd0);
        check("rrst.in_ready_after", 64'(in_ready), 64'd1);
        check("rrst.busy9_cleared", 64'(rs1_busy), 64'd0);
        tick();
        check("rrst.no_pending_write", 64'(rf_wen), 64'd0);
        tick();
        check("rrst.no_pending_write2", 64'(rf_wen), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wbu.md
Name: wbu

Overview:
- Write-back unit directly upstream of the integer register file.
- Merges ALU results (valid/ready handshake) and load returns (valid-only, always accepted) onto the register file's single write port.
- Holds one ALU result in a pending buffer when a load collides with it.
- Keeps a per-register busy scoreboard so decode can detect read-after-write hazards on rs1/rs2.

Parameters:
- ADDR_WIDTH, 5, register index width; register count is 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- iss_valid  input  1  an instruction is issued this cycle.
- iss_rd  input  ADDR_WIDTH  destination of the issued instruction; marks it busy.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  wbu accepts the ALU result this cycle.
- in_wen  input  1  the ALU instruction writes rd.
- in_rd  input  ADDR_WIDTH  ALU destination.
- in_data  input  DATA_WIDTH  ALU result.
- ld_valid  input  1  load data returns; must be consumed this cycle.
- ld_rd  input  ADDR_WIDTH  load destination.
- ld_data  input  DATA_WIDTH  load data.
- chk_rs1  input  ADDR_WIDTH  hazard query index 1.
- chk_rs2  input  ADDR_WIDTH  hazard query index 2.
- rs1_busy  output  1  chk_rs1 has a write outstanding.
- rs2_busy  output  1  chk_rs2 has a write outstanding.
- rf_wen  output  1  register file write enable.
- rf_waddr  output  ADDR_WIDTH  register file write index.
- rf_wdata  output  DATA_WIDTH  register file write data.

Behaviour:
- Reset (rst high at a rising edge): busy vector = 0, pend_v = 0, rf_wen = 0, rf_waddr = 0, rf_wdata = 0. in_ready is 0 while rst is high.
- Write requests. Only these count as requests; anything else is ignored:
  - ALU: in_valid && in_ready && in_wen && in_rd != 0 ("alu_req").
  - Load: ld_valid && ld_rd != 0 ("ld_req").
  - An accepted ALU beat with in_wen = 0 or in_rd = 0 is consumed with no write and no buffering.
- in_ready = !pend_v && !rst. There is no other backpressure source.
- Write-slot priority each cycle (exactly one winner, or none):
  1. ld_req.
  2. Pending buffer (pend_v).
  3. alu_req.
- The winner is registered into rf_wen/rf_waddr/rf_wdata at the next edge. Latency from accepted request to rf_wen high is exactly 1 cycle. If there is no winner, rf_wen = 0 next cycle, and rf_waddr/rf_wdata hold their previous values.
- Pending buffer:
  - alu_req together with ld_req: the ALU rd/data load into the pending buffer and pend_v is set.
  - pend_v with no ld_req: the pending entry wins the slot and pend_v clears.
  - pend_v with ld_req: the pending entry holds.
  - in_ready is low while pend_v = 1, so alu_req cannot occur with pend_v = 1.
- Scoreboard:
  - Set busy[iss_rd] on iss_valid when iss_rd != 0.
  - Clear busy[rf_waddr] at the edge ending any cycle with rf_wen = 1.
  - Same index set and cleared in the same cycle: set wins.
  - busy[0] is constant 0.
- rsN_busy = busy[chk_rsN], combinational, and 0 for index 0. There is no bypass: in the cycle rf_wen is high the register still reads busy; from the next cycle the register file holds the data and busy = 0.
- Back-to-back loads every cycle starve a pending entry indefinitely; upstream bounds this. No loss or reordering occurs.
- Reset mid-operation discards the pending entry and all busy bits. No write is emitted in the cycle after reset.

Decomposition:
- Shared package (npc_pkg):
  - ADDR_WIDTH/DATA_WIDTH defaults.
  - x0 index constant.
  - A wb_req struct {rd, data}.
- One natural sub-module: wbu_scoreboard, holding the busy vector, set/clear logic and the two query ports.
- Arbitration and the pending buffer stay in wbu.

Test Plan:
- Reset then idle: rst high for 2 cycles → rf_wen = 0, rf_waddr = 0, rf_wdata = 0, in_ready = 0 during reset and 1 after, rs1_busy = rs2_busy = 0 for every index.
- Single ALU write: iss_rd = 5 in cycle 0; in_valid, in_rd = 5, in_data = 0xDEADBEEF in cycle 2 → rf_wen = 1, waddr = 5, wdata = 0xDEADBEEF in cycle 3; rs1_busy(chk = 5) = 1 in cycles 1–3 and 0 in cycle 4.
- Collision: ld_rd = 3, ld_data = 0x11 and ALU rd = 4, data = 0x22 in the same cycle N → write x3 in N+1, write x4 in N+2; in_ready = 0 in N+1.
- Starvation/hold: pend_v with ld_valid for 3 consecutive cycles → three load writes, then the pending write in the 4th cycle after; in_ready stays low throughout.
- x0 and no-write: in_wen = 0 (rd = 7), in_rd = 0, and ld_rd = 0 → no rf_wen, in_ready stays 1; iss_rd = 0 never sets busy.
- Set/clear race: rf_wen for x9 in the same cycle as iss_rd = 9 → rs1_busy(9) = 1 in the next cycle. Assert rst while pend_v = 1 → pend_v = 0 and no rf_wen after reset.
